// File: rtl/tank_pkg.sv
// Shared types and constants for the tank keyboard controller.
package tank_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam int unsigned KEY_W_BITS = 8;
  localparam int unsigned X_W        = 10;
  localparam int unsigned Y_W        = 9;
  localparam int unsigned POS_W      = 11;
  localparam int unsigned CNT_W      = 8;

  localparam logic [KEY_W_BITS-1:0] KEY_W     = 8'h1A;
  localparam logic [KEY_W_BITS-1:0] KEY_S     = 8'h16;
  localparam logic [KEY_W_BITS-1:0] KEY_A     = 8'h04;
  localparam logic [KEY_W_BITS-1:0] KEY_D     = 8'h07;
  localparam logic [KEY_W_BITS-1:0] KEY_SPACE = 8'h2C;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    FIRE_READY    = 2'd0,
    FIRE_COOL     = 2'd1,
    FIRE_WAIT_REL = 2'd2
  } fire_state_t;

  typedef struct packed {
    logic vld;
    dir_t dir;
  } move_cmd_t;

  // Translate a keycode into a movement request (vld=0 for non-direction keys).
  function automatic move_cmd_t decode_move(input logic [KEY_W_BITS-1:0] kc);
    move_cmd_t cmd;
    cmd.vld = 1'b1;
    cmd.dir = DIR_UP;
    case (kc)
      KEY_W:   cmd.dir = DIR_UP;
      KEY_D:   cmd.dir = DIR_RIGHT;
      KEY_S:   cmd.dir = DIR_DOWN;
      KEY_A:   cmd.dir = DIR_LEFT;
      default: cmd.vld = 1'b0;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator: two-flop synchroniser on the active-low vsync plus a
// falling-edge detector producing a registered one-cycle tick.
module frame_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vs_async,
  output logic o_tick
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Flops reset high so releasing reset never looks like a vsync fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      o_tick  <= 1'b0;
    end else begin
      r_sync1 <= i_vs_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      o_tick  <= r_prev & ~r_sync2;
    end
  end

endmodule

// File: rtl/tank_key_ctrl.sv
// Keyboard-driven tank controller: moves/clamps the tank once per video frame
// and issues rate-limited shot pulses.
// Build option: define TANK_KEY_AUTOFIRE_EN to let a held space bar refire
// every COOLDOWN frames; otherwise space must be released before the next shot.
module tank_key_ctrl
  import tank_pkg::*;
#(
  parameter int unsigned X0        = 304,
  parameter int unsigned Y0        = 224,
  parameter int unsigned STEP      = 2,
  parameter int unsigned TANK_SIZE = 32,
  parameter int unsigned COOLDOWN  = 20
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [KEY_W_BITS-1:0] keycode,
  input  logic                  vga_vs,
  output logic [X_W-1:0]        tank_x,
  output logic [Y_W-1:0]        tank_y,
  output logic [1:0]            tank_dir,
  output logic                  moving,
  output logic                  fire
);

  localparam logic signed [POS_W-1:0] STEP_S  = POS_W'(STEP);
  localparam logic signed [POS_W-1:0] X_MAX_S = POS_W'(SCREEN_W - TANK_SIZE);
  localparam logic signed [POS_W-1:0] Y_MAX_S = POS_W'(SCREEN_H - TANK_SIZE);
  localparam logic [CNT_W-1:0]        CD_LOAD = CNT_W'(COOLDOWN);

  logic                    w_tick;
  move_cmd_t               w_cmd;
  logic                    w_key_fire;
  logic signed [POS_W-1:0] w_x_cur;
  logic signed [POS_W-1:0] w_y_cur;
  logic signed [POS_W-1:0] w_x_try;
  logic signed [POS_W-1:0] w_y_try;
  logic signed [POS_W-1:0] w_x_clamp;
  logic signed [POS_W-1:0] w_y_clamp;
  logic [X_W-1:0]          w_x_new;
  logic [Y_W-1:0]          w_y_new;
  logic                    w_moved;

  logic [X_W-1:0]          r_x;
  logic [Y_W-1:0]          r_y;
  dir_t                    r_dir;
  logic                    r_moving;
  logic                    r_fire;

  fire_state_t             r_state;
  fire_state_t             w_state_next;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_next;
  logic                    w_fire_set;

  frame_tick_gen u_tick (
    .clk        (clk_clk),
    .rst_n      (reset_reset_n),
    .i_vs_async (vga_vs),
    .o_tick     (w_tick)
  );

  assign w_cmd      = decode_move(keycode);
  assign w_key_fire = (keycode == KEY_SPACE);
  assign w_x_cur    = $signed(POS_W'(r_x));
  assign w_y_cur    = $signed(POS_W'(r_y));

  // Candidate position one STEP in the requested direction (signed, may go negative).
  always_comb begin
    w_x_try = w_x_cur;
    w_y_try = w_y_cur;
    if (w_cmd.vld) begin
      case (w_cmd.dir)
        DIR_UP:    w_y_try = w_y_cur - STEP_S;
        DIR_RIGHT: w_x_try = w_x_cur + STEP_S;
        DIR_DOWN:  w_y_try = w_y_cur + STEP_S;
        DIR_LEFT:  w_x_try = w_x_cur - STEP_S;
        default:   ;
      endcase
    end
  end

  // Clamp the candidate against the screen edges so the tank never wraps.
  always_comb begin
    w_x_clamp = w_x_try;
    w_y_clamp = w_y_try;
    if (w_x_try[POS_W-1]) begin
      w_x_clamp = '0;
    end else if (w_x_try > X_MAX_S) begin
      w_x_clamp = X_MAX_S;
    end
    if (w_y_try[POS_W-1]) begin
      w_y_clamp = '0;
    end else if (w_y_try > Y_MAX_S) begin
      w_y_clamp = Y_MAX_S;
    end
  end

  assign w_x_new = X_W'(w_x_clamp);
  assign w_y_new = Y_W'(w_y_clamp);
  assign w_moved = (w_x_new != r_x) || (w_y_new != r_y);

  // Position/direction state, updated only on the frame tick.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_x      <= X_W'(X0);
      r_y      <= Y_W'(Y0);
      r_dir    <= DIR_UP;
      r_moving <= 1'b0;
    end else if (w_tick) begin
      r_x      <= w_x_new;
      r_y      <= w_y_new;
      r_moving <= w_moved;
      if (w_cmd.vld) begin
        r_dir <= w_cmd.dir;
      end
    end
  end

  // Fire FSM state register, cooldown counter and shot pulse.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= FIRE_READY;
      r_cnt   <= '0;
      r_fire  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_fire  <= w_fire_set;
    end
  end

  // Fire FSM next-state logic; everything advances only on the frame tick.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_fire_set   = 1'b0;
    if (w_tick) begin
      case (r_state)
        FIRE_READY: begin
          if (w_key_fire) begin
            w_fire_set   = 1'b1;
            w_cnt_next   = CD_LOAD;
            w_state_next = FIRE_COOL;
          end
        end
        FIRE_COOL: begin
          w_cnt_next = r_cnt - CNT_W'(1);
          if (r_cnt <= CNT_W'(1)) begin
`ifdef TANK_KEY_AUTOFIRE_EN
            // Expiring tick is judged as READY so a held key refires every COOLDOWN ticks.
            if (w_key_fire) begin
              w_fire_set   = 1'b1;
              w_cnt_next   = CD_LOAD;
              w_state_next = FIRE_COOL;
            end else begin
              w_state_next = FIRE_READY;
            end
`else
            w_state_next = FIRE_WAIT_REL;
`endif
          end
        end
        FIRE_WAIT_REL: begin
          if (!w_key_fire) begin
            w_state_next = FIRE_READY;
          end
        end
        default: w_state_next = FIRE_READY;
      endcase
    end
  end

  assign tank_x   = r_x;
  assign tank_y   = r_y;
  assign tank_dir = r_dir;
  assign moving   = r_moving;
  assign fire     = r_fire;

endmodule

// File: doc/tank_key_ctrl.md
TANK_KEY_CTRL -- requirements
Module: tank_key_ctrl

Interface
REQ-001 SHALL have parameter X0, 304, reset X position (pixels).
REQ-002 SHALL have parameter Y0, 224, reset Y position (pixels).
REQ-003 SHALL have parameter STEP, 2, pixels moved per frame tick (1..15).
REQ-004 SHALL have parameter TANK_SIZE, 32, tank sprite edge length (pixels).
REQ-005 SHALL have parameter COOLDOWN, 20, frames between shots (1..255; 0 illegal).
REQ-006 SHALL have port clk_clk  in  1  single system clock, all logic rising-edge.
REQ-007 SHALL have port reset_reset_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have port keycode  in  8  USB HID keycode from SoC keycode export (0x00 = none).
REQ-009 SHALL have port vga_vs  in  1  VGA vertical sync from SoC, active-low, asynchronous to clk_clk.
REQ-010 SHALL have port tank_x  out  10  tank left edge.
REQ-011 SHALL have port tank_y  out  9  tank top edge.
REQ-012 SHALL have port tank_dir  out  2  facing: 0 up, 1 right, 2 down, 3 left.
REQ-013 SHALL have port moving  out  1  high while last tick changed position.
REQ-014 SHALL have port fire  out  1  one-cycle shot request pulse.

Function
REQ-015 SHALL synchronise vga_vs through two flops; frame tick = one-cycle pulse when synchronised vs goes 1->0 (tick 3 clocks after input fall is sampled).
REQ-016 SHALL sample keycode only in the tick cycle; keycode changes between ticks have no effect.
REQ-017 SHALL map keycodes: 0x1A W up, 0x16 S down, 0x04 A left, 0x07 D right, 0x2C space fire; all others ignored.
REQ-018 SHALL, on tick with direction key, update tank_dir and move STEP pixels that way, outputs valid the cycle after tick.
REQ-019 SHALL clamp X to [0, 640-TANK_SIZE] and Y to [0, 480-TANK_SIZE] using 11-bit signed intermediates; no wrap-around.
REQ-020 SHALL set moving=1 if the tick changed tank_x/tank_y, else 0 (clamped at wall -> 0, dir still updates); held until next tick.
REQ-021 SHALL implement fire FSM states READY, COOL, WAIT_REL.
REQ-022 READY: tick with 0x2C -> fire=1 for exactly the next cycle, load counter=COOLDOWN, go COOL.
REQ-023 COOL: counter decrements each tick; on tick where counter reaches 0 -> next state per REQ-029.
REQ-024 WAIT_REL: tick with keycode != 0x2C -> READY; else stay.
REQ-025 SHALL never assert fire on consecutive cycles nor more than once per COOLDOWN ticks.
REQ-026 Direction and fire keys are mutually exclusive per tick (single keycode); unknown code -> no move, moving=0, fire FSM treats as released.

Reset
REQ-027 SHALL on reset_reset_n low, immediately: tank_x=X0, tank_y=Y0, tank_dir=0, moving=0, fire=0, FSM=READY, counter=0, sync flops=1 (no false tick after release).
REQ-028 Reset mid-cooldown or mid-move SHALL discard all progress; first tick after release obeys READY rules.

Configuration
REQ-029 SHALL honour macro TANK_KEY_AUTOFIRE_EN: defined -> COOL ends in READY (holding space fires every COOLDOWN ticks); undefined -> COOL ends in WAIT_REL (space must be released for one tick before next shot).

Structure
REQ-030 SHALL place dir_t enum, fire_state_t enum, keycode constants, SCREEN_W=640, SCREEN_H=480 in shared package tank_pkg.
REQ-031 SHALL use one sub-module frame_tick_gen (synchroniser + falling-edge detector).

Verification
REQ-032 Reset, keycode 0x07 for 5 ticks, STEP=2 -> tank_x=314, tank_y=224, tank_dir=1, moving=1.
REQ-033 tank_x=606, keycode 0x07, 3 ticks -> tank_x=608 then 608, moving 1,0,0.
REQ-034 tank_y=1, keycode 0x1A one tick -> tank_y=0, tank_dir=0, no wrap to 479.
REQ-035 COOLDOWN=3, space held 10 ticks: with AUTOFIRE_EN fire pulses at ticks 1,4,7,10; without, only tick 1; release one tick then press -> fire.
REQ-036 keycode 0x07 toggled every cycle between ticks, 0x00 at tick -> no movement.
REQ-037 reset asserted in COOL mid-frame -> outputs at reset values same cycle; first space tick after release -> fire.
